masked_mul_scheduler: RTL

Time-multiplexes one `masked_hpc3_mul` instance between `NUM_REQ` requesters. It arbitrates round-robin, registers the shared operands, and binds exactly one fresh randomness word to every issued multiplication, so no `r`/`p` value is ever reused across products. It tracks the requester ID of each in-flight product through the multiplier's fixed latency and returns each result tagged with that ID. It sits between the S-box sequencing logic and the multiplier, replacing per-product multiplier instances where area matters.

---
 rtl/masked_mul_scheduler_pkg.sv | 29 ++
 rtl/masked_mul_scheduler_rr_arbiter.sv | 41 ++++
 rtl/masked_mul_scheduler.sv | 109 ++++++++++
 3 files changed

// File: rtl/masked_mul_scheduler_pkg.sv
// Shared types and sizing helpers for the masked multiplier scheduler.
package masked_mul_scheduler_pkg;

  localparam int DEF_NUM_SHARES = 3;
  localparam int DEF_BIT_WIDTH  = 1;

  // Number of share pairs (i<j) that each need one fresh randomness bit.
  function automatic int num_quad(input int num_shares);
    return (num_shares * (num_shares - 1)) / 2;
  endfunction

  // Width of a requester index; a single requester still needs one bit.
  function automatic int req_id_width(input int num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

  localparam int DEF_NUM_QUAD = num_quad(DEF_NUM_SHARES);

  // Operand type: one masked value split into shares.
  typedef logic [DEF_NUM_SHARES-1:0][DEF_BIT_WIDTH-1:0] T;

  // Randomness for one product: r in the low half, p in the high half.
  typedef logic [DEF_NUM_QUAD-1:0][DEF_BIT_WIDTH-1:0] quad_t;
  typedef struct packed {
    quad_t p;
    quad_t r;
  } rand_word_t;

endpackage

// File: rtl/masked_mul_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after ptr, wrapping.
module rr_arbiter
  import masked_mul_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = req_id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  // Search the upper part [ptr..N-1] first, then wrap to the lowest request.
  always_comb begin
    logic                found;
    logic [NUM_REQ-1:0]  hit;
    logic [ID_W-1:0]     idx;
    found = 1'b0;
    hit   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        found  = 1'b1;
        hit[i] = 1'b1;
        idx    = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        hit[i] = 1'b1;
        idx    = ID_W'(i);
      end
    end
    grant     = enable ? hit : '0;
    grant_idx = (enable && found) ? idx : '0;
  end

endmodule

// File: rtl/masked_mul_scheduler.sv
// Shares one masked multiplier among several requesters, binding a fresh
// randomness word to every issued product and tagging results with the owner.
module masked_mul_scheduler
  import masked_mul_scheduler_pkg::*;
#(
  parameter int NUM_SHARES  = 3,
  parameter int BIT_WIDTH   = 1,
  parameter int NUM_REQ     = 2,
  parameter int MUL_LATENCY = 1
) (
  input  logic                                              in_clock,
  input  logic                                              in_reset,
  input  logic [NUM_REQ-1:0]                                in_req_valid,
  input  logic [NUM_REQ-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] in_req_a,
  input  logic [NUM_REQ-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] in_req_b,
  output logic [NUM_REQ-1:0]                                out_req_ready,
  input  logic                                              in_rand_valid,
  input  logic [2*num_quad(NUM_SHARES)*BIT_WIDTH-1:0]       in_rand,
  output logic                                              out_rand_ready,
  output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]              out_mul_a,
  output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]              out_mul_b,
  output logic [num_quad(NUM_SHARES)-1:0][BIT_WIDTH-1:0]    out_mul_r,
  output logic [num_quad(NUM_SHARES)-1:0][BIT_WIDTH-1:0]    out_mul_p,
  input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]              in_mul_c,
  output logic                                              out_rsp_valid,
  output logic [req_id_width(NUM_REQ)-1:0]                  out_rsp_id,
  output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]              out_rsp_c,
  output logic                                              out_busy
);

  localparam int NUM_QUAD = num_quad(NUM_SHARES);
  localparam int ID_W     = req_id_width(NUM_REQ);
  localparam int DEPTH    = MUL_LATENCY + 1;
  localparam int RW       = NUM_QUAD * BIT_WIDTH;

  logic [NUM_REQ-1:0]          grant;
  logic [ID_W-1:0]             grant_idx;
  logic [ID_W-1:0]             ptr;
  logic                        issue;
  logic [DEPTH-1:0]            tag_vld;
  logic [DEPTH-1:0][ID_W-1:0]  tag_id;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (in_req_valid),
    .enable    (in_rand_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A product issues only when a requester and a randomness word meet.
  assign issue          = |grant;
  assign out_req_ready  = grant;
  assign out_rand_ready = issue;

  // Round-robin pointer advances past the winner so it yields next time.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      ptr <= '0;
    end else if (issue) begin
      ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Multiplier inputs: load on issue, otherwise flush to zero so no share
  // of a previous operand lingers on the datapath.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      out_mul_a <= '0;
      out_mul_b <= '0;
      out_mul_r <= '0;
      out_mul_p <= '0;
    end else if (issue) begin
      out_mul_a <= in_req_a[grant_idx];
      out_mul_b <= in_req_b[grant_idx];
      out_mul_r <= in_rand[RW-1:0];
      out_mul_p <= in_rand[2*RW-1:RW];
    end else begin
      out_mul_a <= '0;
      out_mul_b <= '0;
      out_mul_r <= '0;
      out_mul_p <= '0;
    end
  end

  // Tag pipeline follows each product through the multiplier latency.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld[0] <= issue;
      tag_id[0]  <= grant_idx;
      for (int s = 1; s < DEPTH; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  assign out_rsp_valid = tag_vld[DEPTH-1];
  assign out_rsp_id    = tag_id[DEPTH-1];
  assign out_rsp_c     = in_mul_c;
  assign out_busy      = |tag_vld;

endmodule
